// File: rtl/hitgen_sched_pkg.sv
// Shared types and constants for the hit-data generator trigger scheduler.
//   sched_state_t   : scheduler FSM states
//   DEF_TIMEOUT_CYC : default number of cycles the generator has to go busy
//   GAP_W           : width of the inter-stream gap setting
//   src_id_t        : source id wide enough for the largest supported requester count (8)
package hitgen_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } sched_state_t;

  localparam int DEF_TIMEOUT_CYC = 8;
  localparam int GAP_W           = 8;
  localparam int SRC_ID_W        = 3;

  typedef logic [SRC_ID_W-1:0] src_id_t;

endpackage

// File: rtl/hitgen_trigger_sched_rr_arbiter.sv
// Round-robin arbiter, reusable for any shared resource.
//   clk, reset : clock, synchronous active-high reset
//   req        : request vector
//   advance    : move the priority pointer to the current winner
//   grant      : one-hot winner (zero when no request)
//   grant_idx  : index of the winner
//   any_req    : at least one request present
// The search starts one past the last winner and wraps, so after reset
// (pointer = NUM_REQ-1) source 0 has first priority.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] ptr_reg;
  logic             found;
  int               cand;

  assign any_req = |req;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_reg) + k) % NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found                  = 1'b1;
        grant[IDX_W'(cand)]    = 1'b1;
        grant_idx              = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= IDX_W'(NUM_REQ - 1);
    end else if (advance && any_req) begin
      ptr_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/hitgen_trigger_sched.sv
// Trigger scheduler for the hit-data generator. Queues trigger pulses per
// source, grants them round-robin while the generator is idle, and issues a
// single-cycle trigger per stream, followed by an optional inter-stream gap.
//   clk, reset      : clock, synchronous active-high reset
//   enable          : allow new launches (in-flight stream always completes)
//   req_trig        : per-source trigger pulses
//   req_mask        : per-source enable; masked pulses are dropped
//   gap_cycles      : idle cycles forced after each stream end
//   clear_err       : clears overflow / timeout flags
//   hitgen_trigger  : trigger pulse to the generator
//   hitgen_done     : generator idle indication (low while streaming)
//   active_src      : source of the current / last stream
//   stream_start    : pulse coincident with hitgen_trigger
//   stream_end      : pulse after hitgen_done returns high
//   sched_busy      : scheduler not idle
//   overflow        : sticky per-source pending-counter overflow
//   timeout_err     : sticky, generator never went busy after a trigger
//   streams_issued  : wrapping trigger count
module hitgen_trigger_sched
  import hitgen_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int IDX_W      = $clog2(NUM_REQ),
  localparam int TMO_W      = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req_trig,
  input  logic [NUM_REQ-1:0] req_mask,
  input  logic [GAP_W-1:0]   gap_cycles,
  input  logic               clear_err,
  output logic               hitgen_trigger,
  input  logic               hitgen_done,
  output logic [IDX_W-1:0]   active_src,
  output logic               stream_start,
  output logic               stream_end,
  output logic               sched_busy,
  output logic [NUM_REQ-1:0] overflow,
  output logic               timeout_err,
  output logic [15:0]        streams_issued
);

  sched_state_t       state_reg, state_next;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_elig;
  logic               fire_go;
  logic               tmo_hit;
  logic               end_hit;
  logic [TMO_W-1:0]   tmo_cnt_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic [IDX_W-1:0]   active_src_reg;
  logic [15:0]        streams_reg;
  logic               timeout_reg;
  logic               stream_end_reg;

  // Grant happens on the IDLE->FIRE edge; the granted counter drops on the same edge.
  assign fire_go = (state_reg == IDLE) && enable && any_elig && hitgen_done;
  assign tmo_hit = (state_reg == WAIT_BUSY) && hitgen_done &&
                   (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));
  assign end_hit = (state_reg == WAIT_DONE) && hitgen_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (eligible),
    .advance   (fire_go),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_elig)
  );

  // Per-source pending counters and sticky overflow flags.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_src
    logic [CNT_W-1:0] cnt_reg;
    logic             ovf_reg;
    logic             inc;
    logic             dec;
    logic             ovf_set;

    assign inc     = req_trig[gi] & req_mask[gi];
    assign dec     = fire_go & grant[gi];
    assign ovf_set = inc && !dec && (cnt_reg == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
        ovf_reg <= 1'b0;
      end else begin
        if (inc && !dec && !ovf_set) begin
          cnt_reg <= cnt_reg + 1'b1;
        end else if (dec && !inc) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
        // A new overflow outranks a simultaneous clear.
        if (ovf_set) begin
          ovf_reg <= 1'b1;
        end else if (clear_err) begin
          ovf_reg <= 1'b0;
        end
      end
    end

    // Masking only hides the source; its queued count is kept.
    assign eligible[gi] = (cnt_reg != '0) & req_mask[gi];
    assign overflow[gi] = ovf_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (fire_go) state_next = FIRE;
      FIRE:      state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!hitgen_done)  state_next = WAIT_DONE;
        else if (tmo_hit)  state_next = IDLE;
      end
      WAIT_DONE: begin
        if (hitgen_done) state_next = (gap_cycles != '0) ? GAP : IDLE;
      end
      GAP:       if (gap_cnt_reg <= GAP_W'(1)) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      active_src_reg <= '0;
      streams_reg    <= '0;
      tmo_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      timeout_reg    <= 1'b0;
      stream_end_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (fire_go) active_src_reg <= grant_idx;
      if (state_reg == FIRE) streams_reg <= streams_reg + 16'd1;
      tmo_cnt_reg <= (state_reg == WAIT_BUSY) ? tmo_cnt_reg + 1'b1 : '0;
      // Gap length is captured once, when the stream ends.
      if (end_hit) begin
        gap_cnt_reg <= gap_cycles;
      end else if (state_reg == GAP) begin
        gap_cnt_reg <= gap_cnt_reg - 1'b1;
      end
      stream_end_reg <= end_hit;
      if (tmo_hit) begin
        timeout_reg <= 1'b1;
      end else if (clear_err) begin
        timeout_reg <= 1'b0;
      end
    end
  end

  // Pure state/register decodes: no input reaches these outputs combinationally.
  assign hitgen_trigger = (state_reg == FIRE);
  assign stream_start   = (state_reg == FIRE);
  assign stream_end     = stream_end_reg;
  assign sched_busy     = (state_reg != IDLE);
  assign active_src     = active_src_reg;
  assign timeout_err    = timeout_reg;
  assign streams_issued = streams_reg;

endmodule

// File: tb/tb_hitgen_trigger_sched.sv
// Directed bench for hitgen_trigger_sched. A small generator model drops
// hitgen_done one cycle after each trigger and holds it low for 20 cycles.
module tb_hitgen_trigger_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [3:0]  req_trig = '0;
  logic [3:0]  req_mask = 4'hF;
  logic [7:0]  gap_cycles = '0;
  logic        clear_err = 1'b0;
  logic        hitgen_trigger;
  logic        hitgen_done;
  logic [1:0]  active_src;
  logic        stream_start;
  logic        stream_end;
  logic        sched_busy;
  logic [3:0]  overflow;
  logic        timeout_err;
  logic [15:0] streams_issued;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hitgen_trigger_sched dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .req_trig       (req_trig),
    .req_mask       (req_mask),
    .gap_cycles     (gap_cycles),
    .clear_err      (clear_err),
    .hitgen_trigger (hitgen_trigger),
    .hitgen_done    (hitgen_done),
    .active_src     (active_src),
    .stream_start   (stream_start),
    .stream_end     (stream_end),
    .sched_busy     (sched_busy),
    .overflow       (overflow),
    .timeout_err    (timeout_err),
    .streams_issued (streams_issued)
  );

  // Generator model
  int   busy_cnt = 0;
  logic no_busy = 1'b0;
  always @(posedge clk) begin
    if (reset) busy_cnt <= 0;
    else if (hitgen_trigger && !no_busy) busy_cnt <= 20;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign hitgen_done = (busy_cnt == 0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end else begin
      $display("ok   %s: %0d", tag, $signed(got));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_trig = '0;
    clear_err = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] r);
    req_trig = r;
    tick();
    req_trig = '0;
  endtask

  // Ticks until the selected signal is high; n = ticks taken, or -1 on expiry.
  // which: 0 = hitgen_trigger, 1 = stream_end, 2 = timeout_err
  task automatic wait_sig(input int which, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((which == 0 && hitgen_trigger) || (which == 1 && stream_end) ||
          (which == 2 && timeout_err)) begin
        n = i;
        return;
      end
    end
  endtask

  initial begin
    int n;
    int d0;
    int d5;
    int cnt;

    // Reset state
    do_reset();
    check("rst_trigger", 32'(hitgen_trigger), 0);
    check("rst_start", 32'(stream_start), 0);
    check("rst_end", 32'(stream_end), 0);
    check("rst_busy", 32'(sched_busy), 0);
    check("rst_src", 32'(active_src), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_tmo", 32'(timeout_err), 0);
    check("rst_issued", 32'(streams_issued), 0);

    // 1. Single request, latency 2, stream end 22 cycles after trigger
    pulse(4'b0100);
    check("t1_trig_n1", 32'(hitgen_trigger), 0);
    tick();
    check("t1_trig_n2", 32'(hitgen_trigger), 1);
    check("t1_start", 32'(stream_start), 1);
    check("t1_src", 32'(active_src), 2);
    wait_sig(1, 40, n);
    check("t1_end_delay", n, 22);
    check("t1_busy_after", 32'(sched_busy), 0);
    check("t1_issued", 32'(streams_issued), 1);

    // 2. All four at once: order 0,1,2,3, spaced 23 cycles, then nothing left
    do_reset();
    pulse(4'b1111);
    wait_sig(0, 5, n);
    check("t2_first_lat", n, 1);
    check("t2_src0", 32'(active_src), 0);
    for (int s = 1; s < 4; s++) begin
      wait_sig(0, 40, n);
      check($sformatf("t2_gap%0d", s), n, 23);
      check($sformatf("t2_src%0d", s), 32'(active_src), s);
    end
    wait_sig(0, 60, n);
    check("t2_drained", n, -1);
    check("t2_issued", 32'(streams_issued), 4);

    // 3. Overflow on source 1 while a stream runs
    do_reset();
    pulse(4'b0010);
    wait_sig(0, 5, n);
    check("t3_trig", n, 1);
    for (int i = 0; i < 17; i++) begin
      req_trig = 4'b0010;
      tick();
    end
    req_trig = 4'b0010;
    clear_err = 1'b1;
    tick();
    req_trig = '0;
    clear_err = 1'b0;
    check("t3_ovf_set_wins", 32'(overflow), 32'h2);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t3_ovf_cleared", 32'(overflow), 0);
    cnt = 0;
    for (int i = 0; i < 450; i++) begin
      tick();
      if (hitgen_trigger && active_src == 2'd1) cnt++;
    end
    check("t3_drained_cnt", cnt, 15);
    check("t3_issued", 32'(streams_issued), 16);

    // 4. Gap adds exactly gap_cycles between back-to-back triggers
    do_reset();
    gap_cycles = 8'd0;
    pulse(4'b0011);
    wait_sig(0, 5, n);
    wait_sig(0, 60, d0);
    check("t4_spacing_gap0", d0, 23);
    do_reset();
    gap_cycles = 8'd5;
    pulse(4'b0011);
    wait_sig(0, 5, n);
    wait_sig(0, 60, d5);
    check("t4_spacing_gap5", d5, 28);
    check("t4_delta", d5 - d0, 5);
    gap_cycles = 8'd0;

    // 5. Generator never goes busy -> timeout
    do_reset();
    no_busy = 1'b1;
    pulse(4'b0001);
    wait_sig(0, 5, n);
    check("t5_trig", n, 1);
    wait_sig(2, 20, n);
    check("t5_tmo_delay", n, 9);
    check("t5_idle", 32'(sched_busy), 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t5_tmo_cleared", 32'(timeout_err), 0);
    no_busy = 1'b0;

    // 6. Reset in WAIT_DONE discards queue; enable gating
    do_reset();
    pulse(4'b0011);
    wait_sig(0, 5, n);
    for (int i = 0; i < 5; i++) tick();
    check("t6_busy_pre", 32'(sched_busy), 1);
    reset = 1'b1;
    tick();
    check("t6_rst_trigger", 32'(hitgen_trigger), 0);
    check("t6_rst_busy", 32'(sched_busy), 0);
    check("t6_rst_issued", 32'(streams_issued), 0);
    check("t6_rst_src", 32'(active_src), 0);
    reset = 1'b0;
    wait_sig(0, 40, n);
    check("t6_queue_flushed", n, -1);
    enable = 1'b0;
    pulse(4'b0100);
    wait_sig(0, 30, n);
    check("t6_held_disabled", n, -1);
    enable = 1'b1;
    wait_sig(0, 5, n);
    check("t6_reenable_lat", n, 1);
    check("t6_reenable_src", 32'(active_src), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
